rcc_ahb_slv_fe: RTL and testbench
=================================

RCC_AHB_SLV_FE -- requirements
Module: rcc_ahb_slv_fe

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter WW, default 4, byte-strobe width (DW/8).
REQ-004 hclk  in  1  single clock; all logic on rising edge.
REQ-005 hresetn  in  1  reset, synchronous, active-low.
REQ-006 hsel  in  1  slave select.
REQ-007 haddr  in  AW  AHB address.
REQ-008 htrans  in  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 hwrite  in  1  1 = write.
REQ-010 hsize  in  3  transfer size.
REQ-011 hwdata  in  DW  write data, valid in data phase.
REQ-012 hready  in  1  bus-level ready.
REQ-013 hreadyout  out  1  slave ready.
REQ-014 hresp  out  1  0 = OKAY, 1 = ERROR.
REQ-015 hrdata  out  DW  read data.
REQ-016 mreq  out  1  register request to rcc_reg.
REQ-017 mwrite  out  1  1 = write request.
REQ-018 maddr  out  AW  captured address.
REQ-019 mwstrb  out  WW  byte strobes; all 0 on reads.
REQ-020 mdata  out  DW  write data.
REQ-021 sready  in  1  register side completes the request this cycle.
REQ-022 sresp  in  1  register-side error.
REQ-023 sdata  in  DW  register read data.

Function
REQ-024 Address phase accepted when hsel & hready & htrans[1] at a rising edge; haddr, hwrite and hsize are registered.
REQ-025 FSM states: IDLE, ACCESS, ERR1, ERR2.
REQ-026 IDLE -> ACCESS on a legal accepted transfer; IDLE -> ERR1 on an illegal one; otherwise stay in IDLE.
REQ-027 Legal transfer: hsize <= 2 and address aligned to the transfer size.
REQ-028 In ACCESS:
  - mreq = 1, maddr = captured address, mwrite = captured hwrite.
  - mdata = hwrite ? hwdata (combinational) : 0.
REQ-029 mwstrb by size, decoded from haddr[1:0]:
  - byte: one-hot.
  - half: 0011 or 1100.
  - word: 1111.
REQ-030 In ACCESS: hreadyout = sready; hrdata = sdata when sready & ~mwrite, else 0.
REQ-031 Zero-wait: sready = 1 in the first ACCESS cycle completes the transfer in one data-phase cycle.
REQ-032 ACCESS with sready = 0 holds mreq and all m* outputs stable; no timeout.
REQ-033 ACCESS completion with sready = 1 and sresp = 0:
  - new accepted legal transfer -> ACCESS (back-to-back);
  - new accepted illegal transfer -> ERR1;
  - no transfer -> IDLE.
REQ-034 ACCESS completion with sready = 1 and sresp = 1 -> ERR1; the error response replaces the OKAY completion, and hreadyout = 0 that cycle.
REQ-035 ERR1: hreadyout = 0, hresp = 1, mreq = 0. ERR2: hreadyout = 1, hresp = 1.
REQ-036 ERR2 -> ACCESS / ERR1 / IDLE by the same rule as REQ-033.
REQ-037 IDLE and BUSY transfers, or hsel = 0: no mreq; OKAY with zero wait.
REQ-038 hreadyout = 1 and hresp = 0 in IDLE.

Reset
REQ-039 When hresetn = 0 at a rising edge:
  - state -> IDLE;
  - mreq = 0, mwrite = 0, maddr = 0, mwstrb = 0, mdata = 0;
  - hreadyout = 1, hresp = 0, hrdata = 0.
  The next cycle honours a new address phase.
REQ-040 Reset during ACCESS or ERR1/ERR2 aborts the transfer; mreq deasserts the cycle after the reset edge.

Configuration
REQ-041 Macro RCC_AHB_ERR_RESP_EN.
  - Defined: REQ-034 to REQ-036 apply.
  - Undefined: hresp is tied to 0; sresp is ignored; ERR1/ERR2 are absent; illegal transfers complete OKAY with zero wait, no mreq, hrdata = 0.

Structure
REQ-042 Shared package rcc_pkg holds:
  - htrans encodings;
  - hsize encodings;
  - FSM state enum;
  - the AW/DW/WW default constants.
REQ-043 One sub-module, rcc_ahb_strb_gen: combinational hsize/haddr[1:0] -> strobe and legality.

Verification
REQ-044 Word write 0x0000_0010, data 0xA5A5_1234, sready = 1 -> mreq one cycle, mwstrb = 1111, mdata = 0xA5A5_1234, hreadyout = 1, hresp = 0.
REQ-045 Byte read 0x13, sready low for 3 cycles -> mwstrb = 0000, mreq held 4 cycles, hreadyout = 0 for 3 cycles; completion hrdata = sdata.
REQ-046 Half write 0x0000_0001 -> with macro: no mreq, ERR1 then ERR2 (hreadyout 0 then 1, hresp 1 both); without macro: OKAY, no mreq.
REQ-047 Read with sresp = 1 at completion (macro on) -> two-cycle ERROR; next queued NONSEQ still issues mreq.
REQ-048 Back-to-back NONSEQ write 0x04 then read 0x08, sready = 1 -> mreq high 2 consecutive cycles, no wait states.
REQ-049 hresetn low during ACCESS with sready = 0 -> mreq = 0 and hreadyout = 1 the next cycle; a following write completes normally.

Source files
------------

// File: rtl/rcc_pkg.sv
// rcc_pkg: shared AHB encodings, FSM state type and default widths
// for the rcc AHB slave front end and its strobe generator.
package rcc_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int WW_DEF = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } fe_state_e;

endpackage

// File: rtl/rcc_ahb_strb_gen.sv
// rcc_ahb_strb_gen: hsize + haddr[1:0] -> byte strobes and legality.
// Ports: size, alow in; strb (WW), legal out. Illegal gives strb = 0.
module rcc_ahb_strb_gen
  import rcc_pkg::*;
#(
  parameter int WW = WW_DEF
) (
  input  logic [2:0]    size,
  input  logic [1:0]    alow,
  output logic [WW-1:0] strb,
  output logic          legal
);

  logic [3:0] s4;

  always_comb begin
    s4    = 4'b0000;
    legal = 1'b0;
    unique case (1'b1)
      (size == HSIZE_BYTE): begin
        legal = 1'b1;
        s4    = 4'b0001 << alow;
      end
      (size == HSIZE_HALF): begin
        legal = ~alow[0];
        s4    = alow[1] ? 4'b1100 : 4'b0011;
      end
      (size == HSIZE_WORD): begin
        legal = (alow == 2'b00);
        s4    = 4'b1111;
      end
      default: ;
    endcase
    strb = legal ? WW'(s4) : '0;
  end

endmodule

// File: rtl/rcc_ahb_slv_fe.sv
// rcc_ahb_slv_fe: AHB-lite slave front end issuing mreq to rcc_reg.
// Ports: AHB slave (hsel..hrdata), register side (mreq..mdata, sready,
// sresp, sdata). RCC_AHB_ERR_RESP_EN enables the two-cycle ERROR path.
module rcc_ahb_slv_fe
  import rcc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [DW-1:0] hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata,
  output logic          mreq,
  output logic          mwrite,
  output logic [AW-1:0] maddr,
  output logic [WW-1:0] mwstrb,
  output logic [DW-1:0] mdata,
  input  logic          sready,
  input  logic          sresp,
  input  logic [DW-1:0] sdata
);

  fe_state_e     state;
  fe_state_e     state_n;
  fe_state_e     pick;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [WW-1:0] strb_q;
  logic [WW-1:0] strb_d;
  logic          legal;
  logic          is_xfer;
  logic          accept;
  logic          serr;
  logic          done;
  logic          open;
  logic          load;

`ifdef RCC_AHB_ERR_RESP_EN
  localparam fe_state_e ST_BAD = ST_ERR1;
  assign serr = sresp;
`else
  // Illegal transfers complete OKAY; sresp has no effect.
  localparam fe_state_e ST_BAD = ST_IDLE;
  logic unused_sresp;
  assign unused_sresp = sresp;
  assign serr = 1'b0;
`endif

  rcc_ahb_strb_gen #(
    .WW(WW)
  ) u_strb (
    .size (hsize),
    .alow (haddr[1:0]),
    .strb (strb_d),
    .legal(legal)
  );

  always_comb begin
    is_xfer = 1'b0;
    unique case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: is_xfer = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  is_xfer = 1'b0;
    endcase
  end

  assign accept = hsel & hready & is_xfer;
  assign done   = sready & ~serr;

  // A new address phase is only taken where the data
  // phase ends OKAY-ready (IDLE, ERR2, clean completion).
  assign open = (state == ST_IDLE)
              | (state == ST_ERR2)
              | ((state == ST_ACCESS) & done);
  assign load = open & accept & legal;

  always_comb begin
    pick = ST_IDLE;
    if (accept) pick = legal ? ST_ACCESS : ST_BAD;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
    end else if (load) begin
      addr_q  <= haddr;
      write_q <= hwrite;
      strb_q  <= hwrite ? strb_d : '0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   state_n = pick;
      ST_ACCESS: begin
        if (sready) state_n = serr ? ST_ERR1 : pick;
      end
`ifdef RCC_AHB_ERR_RESP_EN
      ST_ERR1:   state_n = ST_ERR2;
      ST_ERR2:   state_n = pick;
`endif
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    mreq      = 1'b0;
    mwrite    = 1'b0;
    maddr     = '0;
    mwstrb    = '0;
    mdata     = '0;
    unique case (state)
      ST_ACCESS: begin
        mreq      = 1'b1;
        mwrite    = write_q;
        maddr     = addr_q;
        mwstrb    = strb_q;
        mdata     = write_q ? hwdata : '0;
        // A register error turns the completion into a wait
        // state; ERR1/ERR2 then carry the ERROR response.
        hreadyout = done;
        hrdata    = (sready & ~write_q) ? sdata : '0;
      end
`ifdef RCC_AHB_ERR_RESP_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rcc_ahb_slv_fe.sv
// tb_rcc_ahb_slv_fe: random + directed AHB traffic, queue scoreboard
// for register requests and AHB responses of rcc_ahb_slv_fe.
module tb_rcc_ahb_slv_fe;
  import rcc_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mreq;
  logic        mwrite;
  logic [31:0] maddr;
  logic [3:0]  mwstrb;
  logic [31:0] mdata;
  logic        sready = 1'b0;
  logic        sresp = 1'b0;
  logic [31:0] sdata = '0;

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  rcc_ahb_slv_fe #(
    .AW(32),
    .DW(32),
    .WW(4)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hsel     (hsel),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hwdata   (hwdata),
    .hready   (hready),
    .hreadyout(hreadyout),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .mreq     (mreq),
    .mwrite   (mwrite),
    .maddr    (maddr),
    .mwstrb   (mwstrb),
    .mdata    (mdata),
    .sready   (sready),
    .sresp    (sresp),
    .sdata    (sdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data;
    int          idle;
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } item_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] data;
    int          waits;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          low;
  } rsp_t;

  typedef struct {
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  item_t stim_q[$];
  req_t  req_q[$];
  rsp_t  rsp_q[$];
  plan_t plan_q[$];

  int errors = 0;
  int checks = 0;

`ifdef RCC_AHB_ERR_RESP_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: AHB rules in plain arithmetic.
  task automatic push(item_t it);
    req_t  r;
    rsp_t  e;
    plan_t p;
    int    nb;
    bit    ok;
    logic [3:0] m;
    nb = (it.size <= 3'd2) ? (1 << it.size) : 1;
    ok = (it.size <= 3'd2) && ((it.addr % nb) == 0);
    if (ok) begin
      m       = 4'((1 << nb) - 1);
      m       = m << (it.addr % 4);
      r.addr  = it.addr;
      r.wr    = it.wr;
      r.strb  = it.wr ? m : 4'b0000;
      r.data  = it.wr ? it.data : 32'h0;
      r.waits = it.waits;
      req_q.push_back(r);
      p.waits = it.waits;
      p.err   = it.err;
      p.rdata = it.rdata;
      plan_q.push_back(p);
      e.err   = ERR_ON && it.err;
      e.rdata = it.wr ? 32'h0 : it.rdata;
      e.low   = it.waits + (e.err ? 2 : 0);
    end else begin
      e.err   = ERR_ON;
      e.rdata = 32'h0;
      e.low   = ERR_ON ? 1 : 0;
    end
    rsp_q.push_back(e);
    stim_q.push_back(it);
  endtask

  function automatic item_t mk(logic [31:0] a, logic w, logic [2:0] s,
                               logic [31:0] d, int idle, int waits,
                               logic err);
    item_t it;
    it.addr  = a;
    it.wr    = w;
    it.size  = s;
    it.data  = d;
    it.idle  = idle;
    it.waits = waits;
    it.err   = err;
    it.rdata = $urandom;
    return it;
  endfunction

  task automatic drive_idle();
    int k;
    k      = $urandom_range(0, 2);
    hsel   = (k != 2);
    htrans = (k == 0) ? HTRANS_IDLE :
             (k == 1) ? HTRANS_BUSY : HTRANS_NONSEQ;
    haddr  = $urandom;
    hwrite = 1'($urandom);
    hsize  = 3'($urandom_range(0, 2));
  endtask

  // AHB master: pipelined address/data phases, holds on hready low.
  initial begin : driver
    item_t ap;
    item_t t;
    bit    ap_v;
    bit    rdy;
    bit    rst;
    ap_v = 1'b0;
    forever begin
      @(negedge hclk);
      rdy = hready;
      rst = !hresetn;
      @(posedge hclk);
      #1;
      if (rst) begin
        ap_v   = 1'b0;
        hwdata = $urandom;
        drive_idle();
      end else if (rdy) begin
        if (ap_v && ap.wr) hwdata = ap.data;
        else               hwdata = $urandom;
        ap_v = 1'b0;
        if (stim_q.size() == 0) begin
          drive_idle();
        end else begin
          t = stim_q[0];
          if (t.idle > 0) begin
            t.idle--;
            stim_q[0] = t;
            drive_idle();
          end else begin
            ap     = stim_q.pop_front();
            ap_v   = 1'b1;
            hsel   = 1'b1;
            htrans = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ
                                                 : HTRANS_NONSEQ;
            haddr  = ap.addr;
            hwrite = ap.wr;
            hsize  = ap.size;
          end
        end
      end
    end
  end

  // Register-side responder following per-request plans.
  initial begin : responder
    plan_t p;
    bit    active;
    bit    rst;
    bit    fin;
    int    cnt;
    active = 1'b0;
    cnt    = 0;
    forever begin
      @(negedge hclk);
      rst = !hresetn;
      fin = mreq && sready;
      @(posedge hclk);
      #1;
      if (rst) begin
        active = 1'b0;
        plan_q.delete();
      end else begin
        if (fin) active = 1'b0;
        if (mreq && !active) begin
          if (plan_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL plan: got mreq=1 expected no request");
          end else begin
            p      = plan_q.pop_front();
            cnt    = p.waits;
            active = 1'b1;
          end
        end else if (active) begin
          cnt--;
        end
      end
      if (active) begin
        sready = (cnt == 0);
        sresp  = (cnt == 0) ? p.err : 1'($urandom);
        sdata  = (cnt == 0) ? p.rdata : $urandom;
      end else begin
        sready = 1'($urandom);
        sresp  = 1'($urandom);
        sdata  = $urandom;
      end
    end
  end

  // Monitor: compares DUT outputs against the expectation queues.
  bit dph = 1'b0;
  int low = 0;
  int mcyc = 0;

  always @(negedge hclk) begin : monitor
    req_t r;
    rsp_t e;
    if (!hresetn) begin
      req_q.delete();
      rsp_q.delete();
      dph  = 1'b0;
      low  = 0;
      mcyc = 0;
    end else begin
      if (mreq) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_mreq: got mreq=1 expected 0");
        end else begin
          r = req_q[0];
          mcyc++;
          chk("maddr", maddr, r.addr);
          chk("mwrite", mwrite, r.wr);
          chk("mwstrb", mwstrb, r.strb);
          chk("mdata", mdata, r.data);
          if (sready) begin
            chk("mreq_len", mcyc, r.waits + 1);
            r    = req_q.pop_front();
            mcyc = 0;
          end
        end
      end
      if (dph) begin
        if (!hready) begin
          low++;
        end else if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_rsp: got completion expected none");
        end else begin
          e = rsp_q.pop_front();
          chk("hresp", hresp, e.err);
          chk("wait_cycles", low, e.low);
          if (!e.err) chk("hrdata", hrdata, e.rdata);
          low = 0;
        end
      end else begin
        chk("idle_rdy_resp", {hready, hresp}, 2'b10);
      end
      if (hready) dph = hsel && htrans[1];
    end
  end

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || rsp_q.size() != 0 ||
            req_q.size() != 0) && n < budget) begin
      @(posedge hclk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               rsp_q.size());
    end
    repeat (2) @(posedge hclk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_mreq", mreq, 1'b0);
    chk("rst_mwrite", mwrite, 1'b0);
    chk("rst_maddr", maddr, 32'h0);
    chk("rst_mwstrb", mwstrb, 4'h0);
    chk("rst_mdata", mdata, 32'h0);
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_hrdata", hrdata, 32'h0);
    hresetn = 1'b1;
    repeat (2) @(posedge hclk);

    push(mk(32'h10, 1'b1, HSIZE_WORD, 32'hA5A5_1234, 1, 0, 1'b0));
    push(mk(32'h13, 1'b0, HSIZE_BYTE, 32'h0, 2, 3, 1'b0));
    push(mk(32'h01, 1'b1, HSIZE_HALF, 32'h1111, 2, 0, 1'b0));
    push(mk(32'h20, 1'b0, HSIZE_WORD, 32'h0, 2, 1, 1'b1));
    push(mk(32'h24, 1'b1, HSIZE_WORD, 32'h5A5A, 0, 0, 1'b0));
    push(mk(32'h04, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 2, 0, 1'b0));
    push(mk(32'h08, 1'b0, HSIZE_WORD, 32'h0, 0, 0, 1'b0));
    push(mk(32'h32, 1'b1, HSIZE_HALF, 32'hBEEF_0000, 0, 0, 1'b0));
    push(mk(32'h36, 1'b0, 3'd3, 32'h0, 0, 0, 1'b0));
    drain(500);

    for (int i = 0; i < 300; i++) begin
      item_t it;
      it = mk($urandom, 1'($urandom),
              ($urandom_range(0, 9) == 0) ? 3'd3
                                          : 3'($urandom_range(0, 2)),
              $urandom,
              ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3),
              ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4),
              1'($urandom_range(0, 5) == 0));
      push(it);
    end
    drain(10000);

    push(mk(32'h40, 1'b0, HSIZE_WORD, 32'h0, 0, 20, 1'b0));
    n = 0;
    while (!mreq && n < 50) begin
      @(posedge hclk);
      #2;
      n++;
    end
    chk("rst_test_mreq_seen", mreq, 1'b1);
    @(posedge hclk);
    #2;
    hresetn = 1'b0;
    @(posedge hclk);
    #2;
    chk("abort_mreq", mreq, 1'b0);
    chk("abort_hreadyout", hreadyout, 1'b1);
    chk("abort_hresp", hresp, 1'b0);
    hresetn = 1'b1;
    repeat (2) @(posedge hclk);
    push(mk(32'h44, 1'b1, HSIZE_WORD, 32'h1234_5678, 0, 1, 1'b0));
    push(mk(32'h46, 1'b0, HSIZE_HALF, 32'h0, 0, 0, 1'b0));
    drain(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
